// File: rtl/ace_keymap.sv
// Maps MiSTer PS/2 key events onto the Jupiter Ace 8x5 keyboard matrix, with virtual-SHIFT
// compound keys and a hold timer that stretches short taps past the 50 Hz keyboard scan.
module ace_keymap #(
    parameter int unsigned HOLD_CYCLES = 1300000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  kbd_row,
    output logic [4:0]  kbd_col
);

    localparam logic [20:0] HoldLoad = 21'(HOLD_CYCLES);

    logic [10:0] ev_q, ev_d;
    logic        tog_q, tog_d;
    logic [39:0] phys_q, phys_d;
    logic [39:0] pend_q, pend_d;
    logic [4:0]  comp_q, comp_d;
    logic [4:0]  pendc_q, pendc_d;
    logic [20:0] hold_cnt_q, hold_cnt_d;

    logic        key_hit;
    logic [5:0]  key_idx;
    logic        comp_hit;
    logic [2:0]  comp_idx;
    logic        ev_fire;
    logic        expire;
    logic [39:0] eff;
    logic [4:0]  col_acc;

    // Scancode decode; bit8 only matters for the arrow keys.
    always_comb begin
        key_hit = 1'b1;
        key_idx = 6'd0;
        case (ev_q[7:0])
            8'h12, 8'h59: key_idx = 6'd0;
            8'h14: key_idx = 6'd1;
            8'h1A: key_idx = 6'd2;
            8'h22: key_idx = 6'd3;
            8'h21: key_idx = 6'd4;
            8'h1C: key_idx = 6'd5;
            8'h1B: key_idx = 6'd6;
            8'h23: key_idx = 6'd7;
            8'h2B: key_idx = 6'd8;
            8'h34: key_idx = 6'd9;
            8'h15: key_idx = 6'd10;
            8'h1D: key_idx = 6'd11;
            8'h24: key_idx = 6'd12;
            8'h2D: key_idx = 6'd13;
            8'h2C: key_idx = 6'd14;
            8'h16: key_idx = 6'd15;
            8'h1E: key_idx = 6'd16;
            8'h26: key_idx = 6'd17;
            8'h25: key_idx = 6'd18;
            8'h2E: key_idx = 6'd19;
            8'h45: key_idx = 6'd20;
            8'h46: key_idx = 6'd21;
            8'h3E: key_idx = 6'd22;
            8'h3D: key_idx = 6'd23;
            8'h36: key_idx = 6'd24;
            8'h4D: key_idx = 6'd25;
            8'h44: key_idx = 6'd26;
            8'h43: key_idx = 6'd27;
            8'h3C: key_idx = 6'd28;
            8'h35: key_idx = 6'd29;
            8'h5A: key_idx = 6'd30;
            8'h4B: key_idx = 6'd31;
            8'h42: key_idx = 6'd32;
            8'h3B: key_idx = 6'd33;
            8'h33: key_idx = 6'd34;
            8'h29: key_idx = 6'd35;
            8'h3A: key_idx = 6'd36;
            8'h31: key_idx = 6'd37;
            8'h32: key_idx = 6'd38;
            8'h2A: key_idx = 6'd39;
            default: key_hit = 1'b0;
        endcase

        comp_hit = 1'b0;
        comp_idx = 3'd0;
        if (ev_q[7:0] == 8'h66) begin
            comp_hit = 1'b1;
        end else if (ev_q[8]) begin
            case (ev_q[7:0])
                8'h6B: begin comp_hit = 1'b1; comp_idx = 3'd1; end
                8'h72: begin comp_hit = 1'b1; comp_idx = 3'd2; end
                8'h75: begin comp_hit = 1'b1; comp_idx = 3'd3; end
                8'h74: begin comp_hit = 1'b1; comp_idx = 3'd4; end
                default: ;
            endcase
        end
    end

    always_comb begin
        ev_d       = ps2_key;
        tog_d      = ev_q[10];
        ev_fire    = ev_q[10] != tog_q;
        expire     = hold_cnt_q == 21'd1;
        hold_cnt_d = (hold_cnt_q != '0) ? hold_cnt_q - 21'd1 : '0;
        phys_d     = phys_q;
        pend_d     = pend_q;
        comp_d     = comp_q;
        pendc_d    = pendc_q;

        if (expire) begin
            phys_d  = phys_q & ~pend_q;
            comp_d  = comp_q & ~pendc_q;
            pend_d  = '0;
            pendc_d = '0;
        end

        // A release landing on the expiry cycle (count 1) is applied at once.
        if (ev_fire && key_hit) begin
            if (ev_q[9]) begin
                phys_d[key_idx] = 1'b1;
                pend_d[key_idx] = 1'b0;
                hold_cnt_d      = HoldLoad;
            end else if (hold_cnt_q > 21'd1) begin
                pend_d[key_idx] = 1'b1;
            end else begin
                phys_d[key_idx] = 1'b0;
            end
        end

        if (ev_fire && comp_hit) begin
            if (ev_q[9]) begin
                comp_d[comp_idx]  = 1'b1;
                pendc_d[comp_idx] = 1'b0;
                hold_cnt_d        = HoldLoad;
            end else if (hold_cnt_q > 21'd1) begin
                pendc_d[comp_idx] = 1'b1;
            end else begin
                comp_d[comp_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ev_q       <= ps2_key;
            tog_q      <= ps2_key[10];
            phys_q     <= '0;
            pend_q     <= '0;
            comp_q     <= '0;
            pendc_q    <= '0;
            hold_cnt_q <= '0;
        end else begin
            ev_q       <= ev_d;
            tog_q      <= tog_d;
            phys_q     <= phys_d;
            pend_q     <= pend_d;
            comp_q     <= comp_d;
            pendc_q    <= pendc_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Compound keys: Backspace->0, Left->5, Down->6, Up->7, Right->8, all with SHIFT.
    always_comb begin
        eff = phys_q;
        if (comp_q[0]) eff[20] = 1'b1;
        if (comp_q[1]) eff[19] = 1'b1;
        if (comp_q[2]) eff[24] = 1'b1;
        if (comp_q[3]) eff[23] = 1'b1;
        if (comp_q[4]) eff[22] = 1'b1;
        if (|comp_q)   eff[0]  = 1'b1;

        col_acc = '0;
        for (int r = 0; r < 8; r++) begin
            if (!kbd_row[r]) col_acc = col_acc | eff[r*5 +: 5];
        end
        kbd_col = ~col_acc;
    end

endmodule

// File: tb/tb_ace_keymap.sv
// Self-checking bench for ace_keymap: table-driven matrix scans fed through an expected-value
// queue, plus timed sequences around the hold-counter expiry and reset.
module tb_ace_keymap;

    localparam int unsigned Hold = 100;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [7:0]  kbd_row;
    logic [4:0]  kbd_col;

    ace_keymap #(.HOLD_CYCLES(Hold)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_key (ps2_key),
        .kbd_row (kbd_row),
        .kbd_col (kbd_col)
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] exp_q[$];

    typedef struct {
        int         phase;
        logic [7:0] row;
        logic [4:0] col;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int ph, input logic [7:0] row, input logic [4:0] col);
        vec_t v;
        v.phase = ph;
        v.row   = row;
        v.col   = col;
        vecs.push_back(v);
    endtask

    // Drive a row select, queue its expected column value, then sample and compare.
    task automatic scan(input logic [7:0] row, input logic [4:0] exp, input string name);
        logic [4:0] e;
        @(negedge clk_sys);
        kbd_row = row;
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (kbd_col !== e) begin
            n_fail++;
            $display("FAIL %s: kbd_row=%h kbd_col=%h expected %h", name, row, kbd_col, e);
        end
    endtask

    task automatic run_phase(input int ph);
        foreach (vecs[i]) begin
            if (vecs[i].phase == ph) scan(vecs[i].row, vecs[i].col, $sformatf("phase%0d", ph));
        end
    endtask

    // Returns just after the clock edge on which the event is decoded.
    task automatic send(input logic press, input logic ext, input logic [7:0] code);
        @(posedge clk_sys);
        #1;
        ps2_key = {~ps2_key[10], press, ext, code};
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned p;

        add_vec(1, 8'hFD, 5'h1E);
        add_vec(1, 8'hFE, 5'h1F);
        add_vec(1, 8'h00, 5'h1E);
        add_vec(1, 8'hFF, 5'h1F);
        add_vec(2, 8'hF7, 5'h0F);
        add_vec(2, 8'hFE, 5'h1E);
        add_vec(2, 8'h00, 5'h0E);
        add_vec(2, 8'hFF, 5'h1F);
        add_vec(3, 8'hF7, 5'h0F);
        add_vec(3, 8'hFE, 5'h1E);
        add_vec(4, 8'hF7, 5'h1F);
        add_vec(4, 8'hFE, 5'h1E);
        add_vec(5, 8'h00, 5'h1F);
        add_vec(5, 8'hF7, 5'h1F);
        add_vec(6, 8'hDB, 5'h1E);
        add_vec(6, 8'h00, 5'h1E);
        add_vec(6, 8'hFB, 5'h1E);
        add_vec(6, 8'hDF, 5'h1E);
        add_vec(6, 8'hFE, 5'h1F);
        add_vec(7, 8'hEF, 5'h1E);
        add_vec(7, 8'hFE, 5'h1E);
        add_vec(7, 8'hF7, 5'h1F);

        reset   = 1'b1;
        ps2_key = 11'h000;
        kbd_row = 8'hFF;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        scan(8'h00, 5'h1F, "reset_state");

        // 'A' press, then release long after the hold has run out.
        send(1'b1, 1'b0, 8'h1C);
        run_phase(1);
        repeat (150) @(posedge clk_sys);
        send(1'b0, 1'b0, 8'h1C);
        scan(8'hFD, 5'h1F, "release_no_hold");

        // Short tap is stretched to exactly Hold cycles after the press.
        send(1'b1, 1'b0, 8'h1C);
        p = cyc;
        repeat (7) @(posedge clk_sys);
        send(1'b0, 1'b0, 8'h1C);
        scan(8'hFD, 5'h1E, "tap_held");
        wait_until(p + Hold - 1);
        scan(8'hFD, 5'h1E, "hold_last_cycle");
        wait_until(p + Hold);
        scan(8'hFD, 5'h1F, "hold_expired");

        // Release decoded on the expiry cycle takes effect immediately.
        send(1'b1, 1'b0, 8'h34);
        p = cyc;
        wait_until(p + Hold - 3);
        send(1'b0, 1'b0, 8'h34);
        scan(8'hFD, 5'h1F, "release_at_expiry");

        // Re-press decoded on the expiry cycle keeps the pending key down.
        send(1'b1, 1'b0, 8'h15);
        p = cyc;
        send(1'b0, 1'b0, 8'h15);
        wait_until(p + Hold - 3);
        send(1'b1, 1'b0, 8'h15);
        scan(8'hFB, 5'h1E, "press_at_expiry");
        repeat (Hold + 5) @(posedge clk_sys);
        scan(8'hFB, 5'h1E, "press_at_expiry_kept");
        send(1'b0, 1'b0, 8'h15);
        scan(8'hFB, 5'h1F, "q_released");

        // Physical SHIFT plus Left arrow (virtual SHIFT+5).
        send(1'b1, 1'b0, 8'h59);
        send(1'b1, 1'b1, 8'h6B);
        run_phase(2);
        send(1'b0, 1'b1, 8'h6B);
        run_phase(3);
        repeat (Hold + 10) @(posedge clk_sys);
        run_phase(4);
        send(1'b0, 1'b0, 8'h59);
        scan(8'hFE, 5'h1F, "shift_released");

        // Keypad-4 (non-extended 6B) and an unknown code are ignored.
        send(1'b1, 1'b0, 8'h6B);
        send(1'b1, 1'b0, 8'h07);
        run_phase(5);

        // Two keys on different rows sharing column 0.
        send(1'b1, 1'b0, 8'h15);
        send(1'b1, 1'b0, 8'h4D);
        run_phase(6);
        send(1'b0, 1'b0, 8'h15);
        send(1'b0, 1'b0, 8'h4D);
        repeat (Hold + 10) @(posedge clk_sys);
        scan(8'h00, 5'h1F, "qp_released");

        // Backspace, then reset in the middle of its hold.
        send(1'b1, 1'b0, 8'h66);
        run_phase(7);
        @(posedge clk_sys);
        #1;
        reset   = 1'b1;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        scan(8'h00, 5'h1F, "reset_mid_hold");
        repeat (3) @(posedge clk_sys);
        scan(8'h00, 5'h1F, "no_spurious_event");
        send(1'b1, 1'b0, 8'h1C);
        scan(8'hFD, 5'h1E, "post_reset_event");
        scan(8'hFE, 5'h1F, "post_reset_row0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
